serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial unsigned/two's-complement subtractor that computes `i_minuend - i_subtrahend` one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It trades latency for area against the parallel carry-chain adder. It returns its result in the same `{borrow, difference}` (WIDTH+1)-bit format the adder uses for `{carry, sum}`. It sits beside the adder in the arithmetic datapath and is driven by a start/done handshake from the controlling FSM.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≥ 1.
- `i_clk` input 1: the single clock; all state changes on the rising edge.
- `i_rst_n` input 1: synchronous, active-low reset.
- `i_start` input 1: request; sampled only while `o_ready` = 1.
- `i_minuend` input WIDTH: minuend; sampled on the accepting edge.
- `i_subtrahend` input WIDTH: subtrahend; sampled on the accepting edge.
- `o_ready` output 1: high in IDLE only.
- `o_busy` output 1: high in SHIFT and DONE.
- `o_done` output 1: one-cycle pulse; `o_result` is valid from this cycle onward.
- `o_result` output WIDTH+1: `{final borrow, difference}`, held until the next completion.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - On `i_start` = 1, latch both operands into shift registers, clear the borrow register, clear the bit counter, and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:** each cycle:
  - Feed operand LSBs and the borrow register to the full-subtractor.
  - Shift the difference bit into the MSB of the difference shift register.
  - Update the borrow register, shift both operand registers right, and increment the counter.
  - After the WIDTH-th bit, load `o_result` = `{borrow_out, diff}` and go to DONE.
- **DONE:** `o_done` = 1 for exactly one cycle, then go to IDLE unconditionally.
- **Arithmetic:**
  - `o_result[WIDTH-1:0]` = (minuend − subtrahend) mod 2^WIDTH.
  - `o_result[WIDTH]` = 1 exactly when minuend < subtrahend (unsigned).
- **`i_start` outside IDLE:** ignored in SHIFT and DONE. No queuing, and the latched operands are not disturbed.
- **Operand changes after acceptance:** have no effect.
- **Reset:** `i_rst_n` = 0 on any edge, including mid-SHIFT, forces IDLE and discards partial work.
- **Reset values:** `o_result` = 0, `o_done` = 0, `o_busy` = 0, `o_ready` = 1 from the first cycle after reset.
- **WIDTH = 1:** SHIFT lasts one cycle.

## Timing
- Edge 0: `i_start` accepted.
- Edges 1..WIDTH: bits 0..WIDTH−1 processed.
- `o_done` and the new `o_result` become visible after edge WIDTH.
- `o_ready` returns after edge WIDTH+1.
- Minimum start-to-start spacing is WIDTH+2 cycles.
- `o_ready`, `o_busy` and `o_done` are decoded from the registered state; no combinational path from inputs to outputs.
- Counter width: $clog2(WIDTH+1).

## Configuration
- Macro: `SERIAL_SUB_OVERFLOW_EN`.
- **Defined:** adds output port `o_overflow` (1 bit), the signed two's-complement overflow.
  - Asserted when `minuend[MSB] != subtrahend[MSB]` and `diff[MSB] != minuend[MSB]`.
  - Registered with `o_result` on the same edge and held with it.
  - Reset value 0.
- **Undefined:** no port and no logic; all other behaviour is identical.

## Structure
- Shared package `serial_sub_pkg`:
  - State encoding: IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10.
  - Counter-width helper.
- One sub-module, `full_subtractor`: combinational.
  - Inputs: `i_bit1`, `i_bit2`, `i_borrow`.
  - Outputs: `o_diff` = a⊕b⊕bin, `o_borrow` = (~a&b) | (~(a⊕b)&bin).
  - Instantiated once.

## Test plan
All cases use WIDTH = 8.
- 100 − 58 → `o_result` = 9'h02A; `o_done` exactly 8 cycles after the accept edge, for one cycle.
- 5 − 10 → 9'h1FB (borrow = 1). 8'hAA − 8'hAA → 9'h000.
- Start 8'h10 − 8'h01, then pulse `i_start` with 8'hFF − 8'h00 during SHIFT and during DONE → 9'h00F, only one `o_done`, and `o_ready` returns on schedule.
- Assert `i_rst_n` = 0 at the 4th SHIFT cycle:
  - Next cycle `o_result` = 0, `o_busy` = 0, `o_ready` = 1.
  - A new 8'h03 − 8'h01 then gives 9'h002.
- Back-to-back requests with `i_start` held high → completions exactly WIDTH+2 cycles apart, and `o_result` held between them.
- With `SERIAL_SUB_OVERFLOW_EN`:
  - 8'h80 − 8'h01 → 9'h07F, `o_overflow` = 1.
  - 8'h7F − 8'hFF → 9'h180, `o_overflow` = 1.
  - 8'h05 − 8'h03 → `o_overflow` = 0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : FSM state encoding (IDLE / SHIFT / DONE)
//   cnt_width : width of the bit counter for a given operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Bit counter must be able to hold 0..width.
    function automatic int cnt_width(input int width);
        if (width < 1) begin
            return 1;
        end else begin
            return $clog2(width + 1);
        end
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor: computes bit1 - bit2 - borrow.
// Ports:
//   i_bit1   : minuend bit
//   i_bit2   : subtrahend bit
//   i_borrow : incoming borrow
//   o_diff   : difference bit
//   o_borrow : outgoing borrow
module full_subtractor (
    input  logic i_bit1,
    input  logic i_bit2,
    input  logic i_borrow,
    output logic o_diff,
    output logic o_borrow
);

    assign o_diff   = i_bit1 ^ i_bit2 ^ i_borrow;
    assign o_borrow = (~i_bit1 & i_bit2) | (~(i_bit1 ^ i_bit2) & i_borrow);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes i_minuend - i_subtrahend LSB first, one bit
// per clock, through a single full-subtractor cell and a registered borrow.
// Result format is {final borrow, difference}.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds o_overflow (signed
// two's-complement overflow of the subtraction).
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : synchronous active-low reset
//   i_start      : request, sampled only while o_ready = 1
//   i_minuend    : minuend, captured on the accepting edge
//   i_subtrahend : subtrahend, captured on the accepting edge
//   o_ready      : idle, able to accept a request
//   o_busy       : operation in progress (SHIFT or DONE)
//   o_done       : one-cycle completion pulse
//   o_result     : {borrow, difference}, held until the next completion
//   o_overflow   : signed overflow (only with SERIAL_SUB_OVERFLOW_EN)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             o_overflow,
`endif
    output logic [WIDTH:0]   o_result
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] min_r;
    logic [WIDTH-1:0] sub_r;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_next_s;
    logic             borrow_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   result_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             fs_diff_s;
    logic             fs_borrow_s;
    logic             last_bit_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
    // Operand sign bits are shifted out during SHIFT, so keep copies.
    logic             min_msb_r;
    logic             sub_msb_r;
    logic             overflow_r;
`endif

    full_subtractor u_full_subtractor (
        .i_bit1   (min_r[0]),
        .i_bit2   (sub_r[0]),
        .i_borrow (borrow_r),
        .o_diff   (fs_diff_s),
        .o_borrow (fs_borrow_s)
    );

    assign last_bit_s = (cnt_r == LAST_BIT);

    // Difference shift register input: new bit enters at the MSB.
    always_comb begin
        diff_next_s            = diff_r >> 1;
        diff_next_s[WIDTH-1]   = fs_diff_s;
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Status flags registered alongside the state so they track it exactly.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_next_s == ST_IDLE);
            busy_r  <= (state_next_s == ST_SHIFT) || (state_next_s == ST_DONE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand/difference shift registers, borrow, counter and result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            min_r      <= {WIDTH{1'b0}};
            sub_r      <= {WIDTH{1'b0}};
            diff_r     <= {WIDTH{1'b0}};
            borrow_r   <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            result_r   <= {(WIDTH+1){1'b0}};
`ifdef SERIAL_SUB_OVERFLOW_EN
            min_msb_r  <= 1'b0;
            sub_msb_r  <= 1'b0;
            overflow_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        min_r     <= i_minuend;
                        sub_r     <= i_subtrahend;
                        borrow_r  <= 1'b0;
                        cnt_r     <= {CNT_W{1'b0}};
`ifdef SERIAL_SUB_OVERFLOW_EN
                        min_msb_r <= i_minuend[WIDTH-1];
                        sub_msb_r <= i_subtrahend[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    min_r    <= min_r >> 1;
                    sub_r    <= sub_r >> 1;
                    diff_r   <= diff_next_s;
                    borrow_r <= fs_borrow_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (last_bit_s) begin
                        result_r   <= {fs_borrow_s, diff_next_s};
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // On the last bit fs_diff_s is the difference MSB.
                        overflow_r <= (min_msb_r != sub_msb_r) &&
                                      (fs_diff_s != min_msb_r);
`endif
                    end
                end
                default: begin
                    // DONE: hold everything.
                end
            endcase
        end
    end

    assign o_ready  = ready_r;
    assign o_busy   = busy_r;
    assign o_done   = done_r;
    assign o_result = result_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign o_overflow = overflow_r;
`endif

endmodule
